// File: rtl/fa_serial_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: state encodings and default width.
package fa_serial_ctrl_pkg;

   localparam int DEFAULT_WIDTH = 8;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/fa_serial_ctrl_if.sv
// Host-side handshake and operand/result bus of the bit-serial adder.
interface fa_serial_ctrl_if
   import fa_serial_ctrl_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout
   );

endinterface

// File: rtl/fa.sv
// 1-bit full-adder cell, the only arithmetic in the serial adder.
module fa (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/fa_serial_ctrl.sv
// Bit-serial adder: one fa cell walks a WIDTH-bit operand pair LSB first,
// carry held in a register between bits; start/busy/done handshake.
module fa_serial_ctrl
   import fa_serial_ctrl_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   fa_serial_ctrl_if.slave    bus
);

   localparam int             CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   logic [1:0]       state_reg;
   logic [WIDTH-1:0] sa_reg;
   logic [WIDTH-1:0] sb_reg;
   logic [WIDTH-1:0] sr_reg;
   logic [WIDTH-1:0] sum_reg;
   logic             carry_reg;
   logic             cout_reg;
   logic [CW-1:0]    cnt_reg;

   logic             fa_s;
   logic             fa_co;
   logic [WIDTH-1:0] sr_next;
   logic             load;

   fa u_fa (
      .a    (sa_reg[0]),
      .b    (sb_reg[0]),
      .cin  (carry_reg),
      .sum  (fa_s),
      .cout (fa_co)
   );

   // Result bits enter at the MSB so the first bit lands in bit 0 after WIDTH shifts.
   assign sr_next = {fa_s, sr_reg[WIDTH-1:1]};
   assign load    = bus.start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         sa_reg    <= '0;
         sb_reg    <= '0;
         sr_reg    <= '0;
         sum_reg   <= '0;
         carry_reg <= 1'b0;
         cout_reg  <= 1'b0;
         cnt_reg   <= '0;
      end else if (load) begin
         sa_reg    <= bus.a;
         sb_reg    <= bus.b;
         carry_reg <= bus.cin;
         sr_reg    <= '0;
         cnt_reg   <= '0;
         state_reg <= ST_RUN;
      end else begin
         case (state_reg)
            ST_RUN: begin
               sa_reg    <= sa_reg >> 1;
               sb_reg    <= sb_reg >> 1;
               sr_reg    <= sr_next;
               carry_reg <= fa_co;
               if (cnt_reg == LAST) begin
                  sum_reg   <= sr_next;
                  cout_reg  <= fa_co;
                  state_reg <= ST_DONE;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            // IDLE/DONE without start, and the unused encoding, all settle in IDLE.
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy = (state_reg == ST_RUN);
   assign bus.done = (state_reg == ST_DONE);
   assign bus.sum  = sum_reg;
   assign bus.cout = cout_reg;

endmodule
